// File: rtl/fifo_fwft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft_pkg
// Description : Shared constants for the async FIFO first-word-fall-through
//               read stage: buffer occupancy encodings and the read latency
//               of the FIFO RAM port feeding the stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_fwft_pkg;

    // Occupancy of the 2-entry output buffer
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Cycles from fifo_rd_en_o to data valid on fifo_dout_i
    localparam int FIFO_RD_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/fwft_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fwft_skid_buf
// Description : 2-entry head/tail data register pair for the FWFT read stage.
//               A write lands in head or tail as selected by the caller; a
//               shift moves tail into head. The caller guarantees that a
//               head write and a shift never coincide.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_wr_en       - write i_wr_data this edge
//               i_wr_tail     - 1: write targets tail, 0: write targets head
//               i_wr_data     - word to write
//               i_shift       - copy tail into head this edge
//               o_head        - current head word (stream output data)
// Revision    : 1.0 - initial release
// ============================================================================
module fwft_skid_buf
    import fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic                  i_wr_tail,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_shift,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (i_shift) begin
                r_head <= r_tail;
            end
            if (i_wr_en) begin
                if (i_wr_tail) begin
                    r_tail <= i_wr_data;
                end else begin
                    r_head <= i_wr_data;
                end
            end
        end
    end

    assign o_head = r_head;

endmodule
`default_nettype wire

// File: rtl/async_fifo_fwft_rd_stage.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_fwft_rd_stage
// Description : Read-clock-domain output stage of the async FIFO. Turns the
//               standard-mode rd_en/empty interface (1-cycle RAM latency)
//               into a first-word-fall-through valid/ready stream, keeping
//               up to 2 words buffered so a continuously-ready consumer
//               sees 1 word per cycle.
// Ports       : rd_clk, rd_rst  - read clock, asynchronous active-high reset
//               fifo_empty_i    - FIFO empty flag
//               fifo_rd_en_o    - FIFO read strobe (data next cycle)
//               fifo_dout_i     - FIFO RAM read data
//               m_valid_o/m_ready_i/m_data_o - output stream
//               level_o         - buffered + in-flight word count
// Options     : define FWFT_STAGE_LEVEL_EN to generate the registered
//               level_o counter; otherwise level_o is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_fwft_rd_stage
    import fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            level_o
);

    logic [1:0]                 r_cnt;
    // One stage per cycle of RAM read latency; the oldest stage marks
    // data present on fifo_dout_i this cycle.
    logic [FIFO_RD_LATENCY-1:0] r_inflight;

    logic       w_inflight;
    logic       w_pop;
    logic [2:0] w_sum;
    logic       w_cap_head;
    logic       w_shift;

    assign w_inflight = r_inflight[FIFO_RD_LATENCY-1];
    assign m_valid_o  = (r_cnt != OCC_EMPTY);
    assign w_pop      = m_valid_o & m_ready_i;

    // 3-bit evaluation: pop implies cnt >= 1, so this never wraps.
    assign w_sum      = {1'b0, r_cnt} + {2'b00, w_inflight} - {2'b00, w_pop};

    // Issue only when the word would still fit after this edge; this is what
    // bounds occupancy to 2 and keeps a capture from coinciding with cnt==2.
    assign fifo_rd_en_o = ~rd_rst & ~fifo_empty_i & (w_sum <= {1'b0, OCC_ONE});

    // Arriving word goes to head when the buffer is (or becomes) empty.
    assign w_cap_head = (({1'b0, r_cnt} - {2'b00, w_pop}) == 3'd0);
    assign w_shift    = w_pop & (r_cnt == OCC_TWO);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_cnt      <= OCC_EMPTY;
            r_inflight <= '0;
        end else begin
            r_cnt      <= w_sum[1:0];
            r_inflight <= FIFO_RD_LATENCY'(fifo_rd_en_o);
        end
    end

    fwft_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .i_wr_en   (w_inflight),
        .i_wr_tail (~w_cap_head),
        .i_wr_data (fifo_dout_i),
        .i_shift   (w_shift),
        .o_head    (m_data_o)
    );

`ifdef FWFT_STAGE_LEVEL_EN
    // Registered cnt + inflight: next occupancy plus the read issued now.
    logic [1:0] r_level;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_level <= 2'd0;
        end else begin
            r_level <= w_sum[1:0] + {1'b0, fifo_rd_en_o};
        end
    end

    assign level_o = r_level;
`else
    assign level_o = 2'd0;
`endif

    a_occ_max : assert property (@(posedge rd_clk) disable iff (rd_rst)
        w_sum <= {1'b0, OCC_TWO});

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_fwft_rd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_fwft_rd_stage
// Description : Self-checking bench for async_fifo_fwft_rd_stage. A small
//               FIFO model feeds the stage; every word loaded is also queued
//               as the expected stream, and a monitor compares each accepted
//               beat against that queue. Directed checks cover reset,
//               latency, backpressure, drain-on-empty and level_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_fwft_rd_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] level;

    logic       hold_empty;
    logic [7:0] mem [0:4095];
    int         wr_ptr;
    int         rd_ptr;
    logic [7:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rden_count = 0;
    int n_pops   = 0;

`ifdef FWFT_STAGE_LEVEL_EN
    localparam bit c_LVL_EN = 1'b1;
`else
    localparam bit c_LVL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    async_fifo_fwft_rd_stage #(
        .DATA_WIDTH (8)
    ) dut (
        .rd_clk       (clk),
        .rd_rst       (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_dout_i  (fifo_dout),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .level_o      (level)
    );

    // FIFO model: standard mode, one cycle read latency
    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout  <= mem[rd_ptr % 4096];
            rd_ptr     <= rd_ptr + 1;
            rden_count = rden_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [7:0] v);
        mem[wr_ptr % 4096] = v;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < budget) begin
            step(1);
            k++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && !m_valid)}, 32'd1);
    endtask

    // Monitor: a beat is accepted at the next edge when valid & ready
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
                check("stream_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] next_v;

        rst        = 1'b1;
        m_ready    = 1'b0;
        hold_empty = 1'b0;
        wr_ptr     = 0;
        rd_ptr     = 0;
        fifo_dout  = 8'h00;
        #2;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_rden",  {31'd0, fifo_rd_en}, 32'd0);
        check("rst_data",  {24'd0, m_data}, 32'd0);
        check("rst_level", {30'd0, level}, 32'd0);
        step(2);
        rst = 1'b0;

        // ---- Reset mid-operation with 5 words held in the FIFO ----
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        step(4);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, m_valid}, 32'd0);
        check("async_rst_rden",  {31'd0, fifo_rd_en}, 32'd0);
        exp_q.delete();
        wr_ptr = rd_ptr;
        for (int i = 0; i < 4; i++) load(8'(i));
        step(2);
        rst = 1'b0;
        #1;
        check("first_rden", {31'd0, fifo_rd_en}, 32'd1);
        step(1);
        check("lat_valid_n1", {31'd0, m_valid}, 32'd0);
        step(1);
        check("lat_valid_n2", {31'd0, m_valid}, 32'd1);
        check("lat_data_n2",  {24'd0, m_data}, 32'h00);
        m_ready = 1'b1;
        wait_drain(40);

        // ---- Streaming: 16 words, no gaps ----
        for (int i = 1; i <= 16; i++) load(8'(i));
        step(2);
        for (int i = 0; i < 16; i++) begin
            check("stream_valid", {31'd0, m_valid}, 32'd1);
            step(1);
        end
        check("stream_end_valid", {31'd0, m_valid}, 32'd0);

        // ---- Backpressure: 8 words, ready low ----
        m_ready = 1'b0;
        base = rden_count;
        for (int i = 1; i <= 8; i++) load(8'(i));
        step(6);
        check("bp_rden_pulses", rden_count - base, 32'd2);
        check("bp_rden_idle",   {31'd0, fifo_rd_en}, 32'd0);
        check("bp_level", {30'd0, level}, c_LVL_EN ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
            check("bp_hold_data",  {24'd0, m_data}, 32'h01);
            step(1);
        end
        m_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("bp_release_valid", {31'd0, m_valid}, 32'd1);
            step(1);
        end
        check("bp_end_valid", {31'd0, m_valid}, 32'd0);

        // ---- Drain on empty: single word, ready toggling ----
        base = rden_count;
        n_pops = 0;
        load(8'h01);
        for (int i = 0; i < 8; i++) begin
            m_ready = (i % 2 == 0);
            step(1);
        end
        m_ready = 1'b0;
        #1;
        check("drain_rden_pulses", rden_count - base, 32'd1);
        check("drain_beats", n_pops, 32'd1);
        check("drain_valid", {31'd0, m_valid}, 32'd0);
        check("drain_rden",  {31'd0, fifo_rd_en}, 32'd0);

        // ---- Level output under stalled ready ----
        for (int i = 0; i < 4; i++) load(8'h50 + 8'(i));
        check("level_t0", {30'd0, level}, 32'd0);
        step(1);
        check("level_t1", {30'd0, level}, c_LVL_EN ? 32'd1 : 32'd0);
        step(1);
        check("level_t2", {30'd0, level}, c_LVL_EN ? 32'd2 : 32'd0);
        step(1);
        check("level_t3", {30'd0, level}, c_LVL_EN ? 32'd2 : 32'd0);
        m_ready = 1'b1;
        wait_drain(40);

        // ---- Random ready/empty against the scoreboard ----
        next_v = 8'h80;
        for (int i = 0; i < 1000; i++) begin
            m_ready    = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                load(next_v);
                next_v = next_v + 8'd1;
            end
            step(1);
        end
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        wait_drain(2000);
        check("final_rden", {31'd0, fifo_rd_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/async_fifo_fwft_rd_stage.md
Name: async_fifo_fwft_rd_stage

Overview:
- Read-side output stage placed directly downstream of the async FIFO read controller and RAM read port, in the read clock domain.
- Converts the standard-mode FIFO read interface into a first-word-fall-through valid/ready stream:
  - standard-mode side: rd_en/empty handshake, 1-cycle read latency;
  - stream side: first-word-fall-through valid/ready.
- Holds up to 2 words in a registered buffer so throughput stays at 1 word per cycle under continuous ready.

Parameters:
- DATA_WIDTH, 8, width of FIFO data word and stream data.

Ports:
- rd_clk  input  1  read-domain clock.
- rd_rst  input  1  asynchronous, active-high reset.
- fifo_empty_i  input  1  empty flag from the FIFO read controller.
- fifo_rd_en_o  output  1  read strobe to the FIFO; data appears on fifo_dout_i the next cycle.
- fifo_dout_i  input  DATA_WIDTH  FIFO RAM read data.
- m_valid_o  output  1  stream data valid.
- m_ready_i  input  1  downstream accepts the word.
- m_data_o  output  DATA_WIDTH  stream data (head of buffer).
- level_o  output  2  buffered + in-flight word count (optional, see below).

Behaviour:
- Clock and reset: one clock, rd_clk. Reset rd_rst is asynchronous and active-high.
- Reset values:
  - occupancy cnt = 0, inflight = 0;
  - m_valid_o = 0, m_data_o = 0, level_o = 0;
  - fifo_rd_en_o is forced 0 while rd_rst = 1.
- Internal state:
  - 2-entry buffer (head, tail);
  - occupancy cnt in {EMPTY=0, ONE=1, TWO=2};
  - inflight flag = registered fifo_rd_en_o.
- Pop: pop = m_valid_o & m_ready_i. m_valid_o = (cnt != 0). m_data_o = head entry.
- Read issue (combinational): fifo_rd_en_o = ~rd_rst & ~fifo_empty_i & (cnt + inflight - pop <= 1).
  - Evaluate this expression at 3-bit width; no underflow is possible because pop implies cnt >= 1.
- Capture:
  - When inflight = 1, fifo_dout_i is written at the rising edge: into head if cnt - pop == 0, otherwise into tail.
  - On pop with cnt == 2, tail shifts into head in the same edge.
- Occupancy update: cnt_next = cnt + inflight - pop. Never exceeds 2; exceeding 2 is an assertion failure in simulation.
- Transitions:
  - EMPTY→ONE on capture.
  - ONE→TWO on capture without pop.
  - ONE→EMPTY on pop without capture.
  - ONE stays ONE on capture with pop.
  - TWO→ONE on pop (a capture cannot coincide, by the issue rule).
- Latency:
  - rd_en asserted in cycle N, data on fifo_dout_i in N+1, m_valid_o high in N+2.
  - FIFO nonempty → first m_valid_o takes 2 cycles.
- Throughput: 1 word/cycle sustained with m_ready_i held high (steady state cnt=1, inflight=1, pop=1).
- Backpressure: with m_ready_i low, at most 2 words are accepted. After that fifo_rd_en_o stays 0.
- Stability: m_data_o and m_valid_o are stable while m_valid_o=1 and m_ready_i=0.
- FIFO going empty: no new reads are issued; the buffer drains normally. fifo_empty_i deasserting mid-drain resumes reads on the same cycle.
- Simultaneous capture and pop in ONE: head is replaced by the captured word and cnt stays 1.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO pointers are reset in parallel by the same rd_rst.
- Reset deassertion: first rd_en no earlier than the first edge after rd_rst falls.

Optional Feature:
- Macro: FWFT_STAGE_LEVEL_EN.
  - Defined: level_o = cnt + inflight, registered, range 0..2. Used for almost-empty look-ahead by the consumer.
  - Undefined: level_o tied to 2'd0 and no level logic is generated.

Decomposition:
- Shared package fifo_fwft_pkg:
  - occupancy constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2;
  - constant FIFO_RD_LATENCY=1.
- One sub-module, fwft_skid_buf: the 2-entry head/tail register pair with write-select and shift. The issue/occupancy logic stays in the top.

Test Plan:
- Reset: assert rd_rst mid-cycle with the FIFO holding 5 words → m_valid_o=0, fifo_rd_en_o=0 immediately (asynchronous); after release, first word 0x00 appears 2 cycles after the first rd_en.
- Streaming: FIFO preloaded with 0x01..0x10, m_ready_i=1 → m_valid_o high continuously for 16 cycles starting cycle 2, data 0x01..0x10 in order, no gaps.
- Backpressure: m_ready_i=0 with 8 words available → exactly 2 rd_en pulses, cnt=2, m_data_o=0x01 held stable; raise ready → 0x01..0x08 in order, with no gap bubbles after the first.
- Drain on empty: FIFO holds 1 word, m_ready_i toggling 1010 → a single rd_en, one beat of 0x01, then m_valid_o=0 and fifo_rd_en_o=0 while fifo_empty_i=1.
- Concurrent capture/pop: cnt=1 and inflight=1 with m_ready_i=1 → cnt stays 1 and head updates to the next word on the same edge; checker verifies no duplication or loss over 1000 random ready/empty cycles against a scoreboard.
- Level output: with FWFT_STAGE_LEVEL_EN defined, level_o follows 0→1→2 under stalled ready; with the macro undefined, level_o=0 throughout.
